// File: rtl/table_idx_pkg.sv
// Shared register-map helpers and CTRL bit positions for the wavetable index bank.
package table_idx_pkg;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_IMMED  = 1;

    function automatic int shadow_base();
        return 0;
    endfunction

    function automatic int live_base(input int num_ch);
        return num_ch;
    endfunction

    function automatic int ctrl_addr(input int num_ch);
        return 2 * num_ch;
    endfunction

    function automatic int dirty_addr(input int num_ch);
        return 2 * num_ch + 1;
    endfunction

endpackage

// File: rtl/idx_channel_reg.sv
// One voice channel: shadow index, live index and dirty flag.
module idx_channel_reg #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wdata,
    input  logic             commit,
    input  logic             immediate,
    output logic [IDX_W-1:0] o_shadow,
    output logic [IDX_W-1:0] o_live,
    output logic             o_dirty
);

    logic [IDX_W-1:0] r_shadow;
    logic [IDX_W-1:0] r_live;
    logic             r_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (wr_en) begin
            r_shadow <= wdata;
        end
    end

    // An immediate write beats a coincident commit; otherwise commit copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_live <= '0;
        end else if (wr_en && immediate) begin
            r_live <= wdata;
        end else if (commit) begin
            r_live <= r_shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirty <= 1'b0;
        end else if (wr_en && !immediate) begin
            r_dirty <= 1'b1;
        end else if (commit) begin
            r_dirty <= 1'b0;
        end
    end

    assign o_shadow = r_shadow;
    assign o_live   = r_live;
    assign o_dirty  = r_dirty;

endmodule

// File: rtl/table_idx_bank.sv
// Double-buffered bank of per-voice wavetable indices on an Avalon-MM slave;
// shadows are copied to the live outputs together on a sample tick after a commit request.
module table_idx_bank
    import table_idx_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic                    sample_tick,
    output logic [NUM_CH*IDX_W-1:0] out_port,
    output logic                    commit_done
);

    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(ctrl_addr(NUM_CH));
    localparam logic [ADDR_W-1:0] A_DIRTY = ADDR_W'(dirty_addr(NUM_CH));

    logic                w_wr;
    logic                w_ctrl_wr;
    logic                w_commit;
    logic [NUM_CH-1:0]   w_ch_wr;
    logic [NUM_CH-1:0]   w_dirty;
    logic [IDX_W-1:0]    w_shadow [NUM_CH];
    logic [IDX_W-1:0]    w_live   [NUM_CH];

    logic r_pending;
    logic r_immed;
    logic r_commit_done;

    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && (address == A_CTRL);
    assign w_commit  = r_pending & sample_tick;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_ch_wr[g] = w_wr && (address == ADDR_W'(shadow_base() + g));

            idx_channel_reg #(
                .IDX_W (IDX_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .wr_en     (w_ch_wr[g]),
                .wdata     (writedata[IDX_W-1:0]),
                .commit    (w_commit),
                .immediate (r_immed),
                .o_shadow  (w_shadow[g]),
                .o_live    (w_live[g]),
                .o_dirty   (w_dirty[g])
            );

            assign out_port[g*IDX_W +: IDX_W] = w_live[g];
        end
    endgenerate

    // A request landing on a commit edge re-arms pending so it is served on a later tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= 1'b0;
            r_immed       <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= w_commit;
            if (w_ctrl_wr && writedata[CTRL_COMMIT]) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_immed <= writedata[CTRL_IMMED];
            end
        end
    end

    assign commit_done = r_commit_done;

    always_comb begin
        readdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (address == ADDR_W'(shadow_base() + n)) begin
                readdata = 32'(w_shadow[n]);
            end
            if (address == ADDR_W'(live_base(NUM_CH) + n)) begin
                readdata = 32'(w_live[n]);
            end
        end
        if (address == A_CTRL) begin
            readdata[CTRL_COMMIT] = r_pending;
            readdata[CTRL_IMMED]  = r_immed;
        end
        if (address == A_DIRTY) begin
            readdata = 32'(w_dirty);
        end
    end

endmodule

// File: tb/tb_table_idx_bank.sv
// Directed and randomized checks of table_idx_bank against a register-level behavioural model.
`timescale 1ns/100ps
module tb_table_idx_bank;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 4;
    localparam int ADDR_W = 5;

    logic                    clk;
    logic                    reset;
    logic [ADDR_W-1:0]       address;
    logic                    chipselect;
    logic                    write_n;
    logic [31:0]             writedata;
    logic [31:0]             readdata;
    logic                    sample_tick;
    logic [NUM_CH*IDX_W-1:0] out_port;
    logic                    commit_done;

    int errors = 0;
    int checks = 0;

    int unsigned m_shadow [NUM_CH];
    int unsigned m_live   [NUM_CH];
    int unsigned m_dirty;
    bit          m_pending;
    bit          m_immed;
    bit          m_done;

    table_idx_bank #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .sample_tick (sample_tick),
        .out_port    (out_port),
        .commit_done (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input int a);
        if (a < NUM_CH)                      return 32'(m_shadow[a]);
        if (a < 2*NUM_CH)                    return 32'(m_live[a-NUM_CH]);
        if (a == 2*NUM_CH)                   return {30'd0, m_immed, m_pending};
        if (a == 2*NUM_CH+1)                 return 32'(m_dirty);
        return 32'd0;
    endfunction

    function automatic logic [NUM_CH*IDX_W-1:0] model_out();
        logic [NUM_CH*IDX_W-1:0] v;
        v = '0;
        for (int n = 0; n < NUM_CH; n++) v[n*IDX_W +: IDX_W] = m_live[n][IDX_W-1:0];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given bus/tick inputs; model advances by the register-map rules.
    task automatic step(input bit rst, input bit cs, input bit wn, input int a,
                        input logic [31:0] wd, input bit tick);
        bit commit;
        bit wr;
        int unsigned mask;
        mask = (1 << IDX_W) - 1;
        reset = rst; chipselect = cs; write_n = wn; address = ADDR_W'(a);
        writedata = wd; sample_tick = tick;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin m_shadow[n] = 0; m_live[n] = 0; end
            m_dirty = 0; m_pending = 0; m_immed = 0; m_done = 0;
        end else begin
            wr = cs && !wn;
            commit = m_pending && tick;
            if (commit) begin
                for (int n = 0; n < NUM_CH; n++) m_live[n] = m_shadow[n];
                m_dirty = 0;
                m_pending = 0;
            end
            if (wr && a < NUM_CH) begin
                m_shadow[a] = wd & mask;
                if (m_immed) m_live[a] = wd & mask;
                else         m_dirty = m_dirty | (1 << a);
            end
            if (wr && a == 2*NUM_CH) begin
                if (wd[0]) m_pending = 1;
                m_immed = wd[1];
            end
            m_done = commit;
        end
        reset = 0; chipselect = 0; write_n = 1; sample_tick = 0; writedata = '0;
        check("out_port", 32'(out_port), 32'(model_out()));
        check("commit_done", 32'(commit_done), 32'(m_done));
    endtask

    task automatic wr(input int a, input logic [31:0] d, input bit tick = 0);
        step(0, 1, 0, a, d, tick);
    endtask

    task automatic idle(input bit tick = 0);
        step(0, 0, 1, 0, 32'd0, tick);
    endtask

    task automatic rd(input string tag, input int a);
        chipselect = 1; write_n = 1; address = ADDR_W'(a);
        #0.2;
        check(tag, readdata, model_read(a));
        chipselect = 0;
    endtask

    task automatic rd_const(input string tag, input int a, input logic [31:0] exp);
        chipselect = 1; write_n = 1; address = ADDR_W'(a);
        #0.2;
        check(tag, readdata, exp);
        chipselect = 0;
    endtask

    initial begin
        reset = 1; chipselect = 0; write_n = 1; address = '0; writedata = '0; sample_tick = 0;
        for (int n = 0; n < NUM_CH; n++) begin m_shadow[n] = 0; m_live[n] = 0; end
        m_dirty = 0; m_pending = 0; m_immed = 0; m_done = 0;

        // Reset state
        step(1, 0, 1, 0, 32'd0, 0);
        step(1, 0, 1, 0, 32'd0, 1);
        for (int a = 0; a < 32; a++) rd_const("reset_read", a, 32'd0);
        idle(1);

        // Basic commit of SHADOW[2]
        wr(2, 32'hA);
        rd_const("dirty_pre", 9, 32'h4);
        wr(8, 32'h1);
        for (int i = 0; i < 10; i++) idle();
        rd_const("ctrl_pending", 8, 32'h1);
        check("out_before_tick", 32'(out_port), 32'h0);
        idle(1);
        check("out_after_tick", 32'(out_port), 32'h0A00);
        check("done_pulse", 32'(commit_done), 32'h1);
        rd_const("dirty_post", 9, 32'h0);
        rd_const("ctrl_post", 8, 32'h0);
        idle();
        check("done_single", 32'(commit_done), 32'h0);

        // Commit request on the same edge as a tick
        wr(0, 32'h3);
        wr(8, 32'h1, 1);
        check("same_edge_no_commit", 32'(out_port), 32'h0A00);
        rd_const("same_edge_pending", 8, 32'h1);
        idle(1);
        check("next_tick_commit", 32'(out_port), 32'h0A03);

        // Repeated requests give one commit
        wr(8, 32'h1);
        wr(8, 32'h1);
        idle(1);
        idle(1);
        rd("idem_ctrl", 8);

        // Shadow write on the commit edge
        wr(1, 32'h3);
        wr(8, 32'h1);
        idle(1);
        wr(8, 32'h1);
        wr(1, 32'h5, 1);
        rd_const("edge_live1", NUM_CH + 1, 32'h3);
        rd_const("edge_shadow1", 1, 32'h5);
        rd_const("edge_dirty", 9, 32'h2);

        // Immediate mode
        wr(8, 32'h2);
        wr(3, 32'hF);
        rd_const("imm_live3", NUM_CH + 3, 32'hF);
        rd_const("imm_dirty", 9, 32'h2);
        check("imm_no_done", 32'(commit_done), 32'h0);
        wr(0, 32'hFFFF_FFF7);
        rd_const("imm_trunc", 0, 32'h7);
        rd_const("imm_live0", NUM_CH, 32'h7);

        // Immediate write coinciding with a commit edge
        wr(8, 32'h3);
        wr(2, 32'h9, 1);
        rd_const("imm_commit_live2", NUM_CH + 2, 32'h9);
        rd("imm_commit_live1", NUM_CH + 1);

        // Reset while pending
        wr(8, 32'h1);
        step(1, 0, 1, 0, 32'd0, 1);
        idle(1);
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_done", 32'(commit_done), 32'h0);
        wr(31, 32'hFFFF_FFFF);
        rd_const("unmapped", 31, 32'h0);
        for (int a = 0; a < 32; a++) rd("post_rst_read", a);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int a;
            logic [31:0] d;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                             : int'($urandom_range(0, 2*NUM_CH+1));
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = {d[31:2], 2'b0} | 32'($urandom_range(0, 1));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), a, d, ($urandom_range(0, 3) == 0));
            rd("rand_read", int'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
